// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and bitwise round functions for the SHA-256 round engine.
package sha256_pkg;

  localparam int NUM_ROUNDS = 64;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] H_STD = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} sha256_state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// Rolling 16-word message schedule: win[0] is always W_t for the current round.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         advance,
  input  logic [511:0] block_in,
  output logic [31:0]  w_t
);

  logic [31:0] win [16];
  logic [31:0] w_new;

  // Window holds W_t..W_t+15, so the word shifted in is W_t+16.
  assign w_new = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];
  assign w_t   = win[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= block_in[511 - 32*i -: 32];
    end else if (advance) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_new;
    end
  end

endmodule

// File: rtl/sha256_round_engine.sv
// One-round-per-clock SHA-256 compression engine; a..h and counter feed the digest finaliser.
module sha256_round_engine
  import sha256_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [511:0]  block_in,
  input  logic [255:0]  h_init,
  output logic          busy,
  output logic [6:0]    counter_iteration,
  output logic [31:0]   a_out,
  output logic [31:0]   b_out,
  output logic [31:0]   c_out,
  output logic [31:0]   d_out,
  output logic [31:0]   e_out,
  output logic [31:0]   f_out,
  output logic [31:0]   g_out,
  output logic [31:0]   h_out,
  output sha256_state_e state_dbg
);

  sha256_state_e state, state_nx;
  logic [6:0]    counter;
  logic [31:0]   a, b, c, d, e, f, g, h;
  logic          accept, advance;
  logic [31:0]   w_t, t1, t2;

  sha256_msg_sched u_sched (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .advance  (advance),
    .block_in (block_in),
    .w_t      (w_t)
  );

  // LOAD is folded into the accepting edge: IDLE/DONE go straight to RUN.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    advance  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_LOAD: state_nx = ST_RUN;
      ST_RUN: begin
        advance = 1'b1;
        if (counter == 7'(NUM_ROUNDS - 1)) state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign t1 = h + bsig1(e) + ch(e, f, g) + K[counter[5:0]] + w_t;
  assign t2 = bsig0(a) + maj(a, b, c);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      counter <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        counter <= '0;
        {a, b, c, d, e, f, g, h} <= h_init;
      end else if (advance) begin
        counter <= counter + 7'd1;
        h <= g;
        g <= f;
        f <= e;
        e <= d + t1;
        d <= c;
        c <= b;
        b <= a;
        a <= t1 + t2;
      end
    end
  end

  assign busy              = (state == ST_LOAD) || (state == ST_RUN);
  assign counter_iteration = counter;
  assign state_dbg         = state;
  assign a_out = a;
  assign b_out = b;
  assign c_out = c;
  assign d_out = d;
  assign e_out = e;
  assign f_out = f;
  assign g_out = g;
  assign h_out = h;

endmodule
